// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty flags
// and an occupancy count. Storage is a plain array with a synchronous,
// enabled read into the output register, so it maps onto block RAM.
module sync_fifo #(
  parameter int W = 16,
  parameter int A = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         put,
  output logic         full,
  output logic [W-1:0] out,
  input  logic         get,
  output logic         empty,
  output logic [A:0]   count
);

  localparam int         DEPTH     = 2 ** A;
  localparam logic [A:0] DEPTH_CNT = (A + 1)'(DEPTH);

  // Storage has no reset; only control state and the output register do.
  logic [W-1:0] mem [0:DEPTH-1];

  logic [A-1:0] wr_ptr_reg, wr_ptr_next;
  logic [A-1:0] rd_ptr_reg, rd_ptr_next;
  logic [A:0]   count_reg, count_next;
  logic         full_reg, full_next;
  logic         empty_reg, empty_next;
  logic [W-1:0] out_reg;

  logic wr_accept;
  logic rd_accept;

  // Requests are honoured only against the registered flags, and never while
  // reset is high, so a put while full / get while empty is a pure no-op.
  assign wr_accept = put & ~full_reg & ~reset;
  assign rd_accept = get & ~empty_reg & ~reset;

  // Next-state for pointers, occupancy and flags; pointers wrap naturally
  // because they are exactly A bits wide.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + A'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + A'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + (A + 1)'(1);
      2'b01:   count_next = count_reg - (A + 1)'(1);
      default: count_next = count_reg;
    endcase
    full_next  = (count_next == DEPTH_CNT);
    empty_next = (count_next == '0);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
    end
  end

  // Storage write port; a write and a read never hit the same live entry
  // because a full FIFO rejects the write and an empty one rejects the read.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= in;
    end
  end

  // Registered read: out changes only on an accepted read and holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_reg <= '0;
    end else if (rd_accept) begin
      out_reg <= mem[rd_ptr_reg];
    end
  end

  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;
  assign out   = out_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (W=16, A=4): a vector table for the
// directed single-cycle cases, hand-written fill/drain sequences, and a
// randomized run checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W = 16;
  localparam int A = 4;
  localparam int DEPTH = 16;

  logic         clock;
  logic         reset;
  logic [W-1:0] in;
  logic         put;
  logic         full;
  logic [W-1:0] out;
  logic         get;
  logic         empty;
  logic [A:0]   count;

  int checks;
  int failures;

  // Reference model: a queue of stored words plus the last word read out.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_out;

  sync_fifo #(.W(W), .A(A)) dut (
    .clock(clock),
    .reset(reset),
    .in(in),
    .put(put),
    .full(full),
    .out(out),
    .get(get),
    .empty(empty),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         p;
    logic         g;
    logic [W-1:0] d;
    logic [W-1:0] e_out;
    logic [A:0]   e_cnt;
    logic         e_emp;
    logic         e_full;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, update the model at the
  // rising edge, and leave outputs ready for sampling 1 time unit later.
  task automatic step(input logic r, input logic p, input logic g, input logic [W-1:0] d);
    bit can_rd;
    bit can_wr;
    @(negedge clock);
    reset = r;
    put   = p;
    get   = g;
    in    = d;
    @(posedge clock);
    if (r) begin
      model_q.delete();
      model_out = '0;
    end else begin
      can_rd = (model_q.size() > 0);
      can_wr = (model_q.size() < DEPTH);
      if (g && can_rd) model_out = model_q.pop_front();
      if (p && can_wr) model_q.push_back(d);
    end
    #1;
    $display("t=%0t rst=%0b put=%0b get=%0b in=%04h -> out=%04h count=%0d empty=%0b full=%0b",
             $time, r, p, g, d, out, count, empty, full);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_out = '0;
    reset = 1'b1;
    put   = 1'b0;
    get   = 1'b0;
    in    = '0;

    // rst, put, get, in, expected out, count, empty, full (after the edge)
    vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000, 5'd1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000, 5'd2, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 16'h3333, 16'h0000, 5'd3, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1111, 5'd2, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111, 5'd2, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h2222, 5'd1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h3333, 5'd0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h3333, 5'd0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'h3333, 5'd1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h5555, 5'd0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 16'h7777, 16'h5555, 5'd1, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b1, 16'h8888, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(vt[i].rst, vt[i].p, vt[i].g, vt[i].d);
      chk($sformatf("vec%0d_out", i),   32'(out),   32'(vt[i].e_out));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e_emp));
      chk($sformatf("vec%0d_full", i),  32'(full),  32'(vt[i].e_full));
    end

    // Fill to full, drop a put while full, then drain in order.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(i));
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_out", 32'(out), 32'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      chk($sformatf("drain%0d_out", i), 32'(out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("drain_extra_get_out", 32'(out), 32'h000F);

    // From full: simultaneous put/get performs only the read.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    end
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    chk("fullpg_count", 32'(count), 32'd15);
    chk("fullpg_out", 32'(out), 32'h0100);
    chk("fullpg_full", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      chk($sformatf("fullpg_drain%0d_out", i), 32'(out), 32'h0100 + 32'(i));
    end
    chk("fullpg_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("fullpg_no_aaaa", 32'(out), 32'h010F);

    // Randomized traffic with a bias that alternates between filling and
    // draining, and one reset in the middle of the run.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 1000; c++) begin
      int bias;
      logic r;
      logic p;
      logic g;
      bias = ((c / 100) % 2 == 0) ? 75 : 30;
      r = (c == 500);
      p = ($urandom_range(0, 99) < bias);
      g = ($urandom_range(0, 99) < (100 - bias));
      step(r, p, g, 16'($urandom));
      chk($sformatf("rnd%0d_out", c),   32'(out),   32'(model_out));
      chk($sformatf("rnd%0d_count", c), 32'(count), 32'(model_q.size()));
      chk($sformatf("rnd%0d_empty", c), 32'(empty), 32'(model_q.size() == 0));
      chk($sformatf("rnd%0d_full", c),  32'(full),  32'(model_q.size() == DEPTH));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter W, default 16, data word width in bits.
REQ-002 Parameter A, default 4, address width; depth SHALL be 2**A words.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in     input  W  write data, sampled on a write cycle.
REQ-006 put    input  1  write request, one word per cycle asserted.
REQ-007 full   output 1  no free entry; writes are ignored while high.
REQ-008 out    output W  read data register, loaded on an accepted read.
REQ-009 get    input  1  read request, one word per cycle asserted.
REQ-010 empty  output 1  no stored entry; reads are ignored while high.
REQ-011 count  output A+1  number of stored words, 0..2**A.

Function
REQ-012 Accepted write SHALL be defined as put & !full; the word on in SHALL be stored at the write pointer, and the write pointer SHALL advance by 1.
REQ-013 Accepted read SHALL be defined as get & !empty; the word at the read pointer SHALL be loaded into out at the next clock edge, and the read pointer SHALL advance by 1.
REQ-014 Read latency SHALL be one cycle: get at edge N, new out valid after edge N+1 (i.e. from cycle N+1).
REQ-015 out SHALL hold its value until the next accepted read; rejected reads, writes and idle cycles SHALL NOT change out.
REQ-016 Pointers SHALL be A bits wide and wrap from 2**A-1 to 0 modulo 2**A.
REQ-017 count SHALL be incremented on an accepted write alone, decremented on an accepted read alone, and unchanged on both or neither.
REQ-018 full SHALL be registered and equal (count == 2**A) after every edge.
REQ-019 empty SHALL be registered and equal (count == 0) after every edge.
REQ-020 Simultaneous put and get with 0 < count < 2**A SHALL perform both; count unchanged.
REQ-021 Simultaneous put and get while full SHALL perform the read only; the write is dropped; count SHALL become 2**A-1.
REQ-022 Simultaneous put and get while empty SHALL perform the write only; out unchanged; count SHALL become 1 (no write-through to out).
REQ-023 A put while full or a get while empty SHALL be ignored with no change to pointers, count, storage or out.
REQ-024 Data SHALL emerge in write order with no loss or duplication across any number of pointer wraps.
REQ-025 Storage SHALL be a plain register/RAM array with no reset; only pointers, count, flags and out are reset.
REQ-026 The block SHALL be directly connectable to a consumer that pulses get for one cycle and samples out any later cycle before its next get.

Reset
REQ-027 While reset is high at an edge, write pointer, read pointer and count SHALL become 0, empty SHALL become 1, full SHALL become 0 and out SHALL become 0.
REQ-028 reset SHALL take priority over put and get in the same cycle; neither request is accepted.
REQ-029 Reset mid-operation SHALL discard all stored words; the first get after reset with empty high SHALL be ignored.

Verification
REQ-030 Reset, then idle 3 cycles -> empty=1, full=0, count=0, out=0.
REQ-031 Write 0x1111, 0x2222, 0x3333; then get three single-cycle pulses -> out shows 0x1111, 0x2222, 0x3333 one cycle after each get; empty=1 after the third.
REQ-032 Write 16 words 0x0000..0x000F (A=4) -> full=1, count=16; 17th put of 0xFFFF dropped; 16 reads return 0x0000..0x000F.
REQ-033 From full, put 0xAAAA and get in the same cycle -> count=15, out=oldest word, 0xAAAA never read.
REQ-034 From empty, put 0x5555 and get in the same cycle -> out unchanged, count=1, empty=0; next get -> out=0x5555.
REQ-035 Random put/get for 1000 cycles across at least 10 pointer wraps, with reset asserted once mid-run -> output order matches a reference queue cleared at reset, and count/full/empty are consistent every cycle.
